// File: rtl/irig_b_frame_gen_pkg.sv
// IRIG-B frame generator shared definitions: symbol codes, frame layout,
// BCD time bundle and frame/SBS helper functions.
package irig_b_frame_gen_pkg;

    localparam logic [31:0] SYM_0 = 32'd48;
    localparam logic [31:0] SYM_1 = 32'd49;
    localparam logic [31:0] SYM_P = 32'd80;

    localparam logic [99:0] MARK_MASK =
        (100'd1 << 0)  | (100'd1 << 9)  |
        (100'd1 << 19) | (100'd1 << 29) |
        (100'd1 << 39) | (100'd1 << 49) |
        (100'd1 << 59) | (100'd1 << 69) |
        (100'd1 << 79) | (100'd1 << 89) |
        (100'd1 << 99);

    localparam int POS_SEC_U = 1;
    localparam int POS_SEC_T = 6;
    localparam int POS_MIN_U = 10;
    localparam int POS_MIN_T = 15;
    localparam int POS_HR_U  = 20;
    localparam int POS_HR_T  = 25;
    localparam int POS_DAY_U = 30;
    localparam int POS_DAY_T = 35;
    localparam int POS_DAY_H = 40;
    localparam int POS_YR_U  = 50;
    localparam int POS_YR_T  = 55;
    localparam int POS_SBS_L = 80;
    localparam int POS_SBS_H = 90;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [7:0]  year;
        logic [11:0] day;
        logic [7:0]  hour;
        logic [7:0]  min;
        logic [7:0]  sec;
    } bcd_time_t;

    localparam bcd_time_t RESET_TIME = '{
        year: 8'h00,
        day:  12'h001,
        hour: 8'h00,
        min:  8'h00,
        sec:  8'h00
    };

    // Data bits of one frame, LSB of each field first; SBS is merged later.
    function automatic logic [99:0] build_frame(input bcd_time_t t);
        logic [99:0] f;
        f = '0;
        f[POS_SEC_U +: 4] = t.sec[3:0];
        f[POS_SEC_T +: 3] = t.sec[6:4];
        f[POS_MIN_U +: 4] = t.min[3:0];
        f[POS_MIN_T +: 3] = t.min[6:4];
        f[POS_HR_U  +: 4] = t.hour[3:0];
        f[POS_HR_T  +: 2] = t.hour[5:4];
        f[POS_DAY_U +: 4] = t.day[3:0];
        f[POS_DAY_T +: 4] = t.day[7:4];
        f[POS_DAY_H +: 2] = t.day[9:8];
        f[POS_YR_U  +: 4] = t.year[3:0];
        f[POS_YR_T  +: 4] = t.year[7:4];
        return f;
    endfunction

    function automatic logic [99:0] place_sbs(input logic [16:0] s);
        logic [99:0] f;
        f = '0;
        f[POS_SBS_L +: 9] = s[8:0];
        f[POS_SBS_H +: 8] = s[16:9];
        return f;
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [16:0] calc_sbs(
        input logic [7:0] h,
        input logic [7:0] m,
        input logic [7:0] s
    );
        return 17'(bcd2bin(h)) * 17'd3600
             + 17'(bcd2bin(m)) * 17'd60
             + 17'(bcd2bin(s));
    endfunction

endpackage

// File: rtl/irig_b_frame_gen_bcd_time_inc.sv
// Combinational BCD time-of-year +1 s with leap-day rollover, plus a
// range checker for a second (load) time value.
// Ports: cur (time to advance), nxt (cur + 1 s), chk (time to validate),
//        chk_ok (1 when every field of chk is legal BCD and in range).
module bcd_time_inc
    import irig_b_frame_gen_pkg::*;
(
    input  bcd_time_t cur,
    input  bcd_time_t chk,
    output bcd_time_t nxt,
    output logic      chk_ok
);

    function automatic logic [7:0] inc2(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0}
                                : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [11:0] inc3(input logic [11:0] v);
        if (v[3:0] != 4'd9)
            return {v[11:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd9)
            return {v[11:8], v[7:4] + 4'd1, 4'd0};
        else
            return {v[11:8] + 4'd1, 8'h00};
    endfunction

    // Year mod 4 == 0 in BCD: (2*tens + units) mod 4 == 0.
    function automatic logic is_leap(input logic [7:0] y);
        if (y[4])
            return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        else
            return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) ||
                   (y[3:0] == 4'd8);
    endfunction

    function automatic logic [11:0] last_day(input logic [7:0] y);
        return is_leap(y) ? 12'h366 : 12'h365;
    endfunction

    function automatic logic dig_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    logic c_sec;
    logic c_min;
    logic c_hour;
    logic c_day;

    always_comb begin
        c_sec  = (cur.sec == 8'h59);
        c_min  = c_sec && (cur.min == 8'h59);
        c_hour = c_min && (cur.hour == 8'h23);
        c_day  = c_hour && (cur.day == last_day(cur.year));

        nxt.sec  = c_sec ? 8'h00 : inc2(cur.sec);
        nxt.min  = !c_sec ? cur.min
                 : (c_min ? 8'h00 : inc2(cur.min));
        nxt.hour = !c_min ? cur.hour
                 : (c_hour ? 8'h00 : inc2(cur.hour));
        nxt.day  = !c_hour ? cur.day
                 : (c_day ? 12'h001 : inc3(cur.day));
        nxt.year = !c_day ? cur.year
                 : ((cur.year == 8'h99) ? 8'h00 : inc2(cur.year));
    end

    // With every digit legal, BCD compares in numeric order.
    assign chk_ok = dig_ok(chk.sec[3:0])  && dig_ok(chk.sec[7:4])  &&
                    dig_ok(chk.min[3:0])  && dig_ok(chk.min[7:4])  &&
                    dig_ok(chk.hour[3:0]) && dig_ok(chk.hour[7:4]) &&
                    dig_ok(chk.day[3:0])  && dig_ok(chk.day[7:4])  &&
                    dig_ok(chk.day[11:8]) &&
                    dig_ok(chk.year[3:0]) && dig_ok(chk.year[7:4]) &&
                    (chk.sec  <= 8'h59) &&
                    (chk.min  <= 8'h59) &&
                    (chk.hour <= 8'h23) &&
                    (chk.day  != 12'h000) &&
                    (chk.day  <= last_day(chk.year));

endmodule

// File: rtl/irig_b_frame_gen.sv
// IRIG-B frame generator: keeps BCD time-of-year and issues one symbol
// code (48 / 49 / 'P') per 10 ms slot, 100 symbols per frame.
// Ports: clk, rst_n (async, active-low), en, time_load + ld_* (BCD time),
//        ex_sig_B_code (symbol code, 0 when idle), frame_start, sym_idx,
//        load_err (rejected load pulse).
module irig_b_frame_gen
    import irig_b_frame_gen_pkg::*;
#(
    parameter int NUM_10MS = 1_249_999,
    parameter int SYM_NUM  = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        time_load,
    input  logic [7:0]  ld_sec,
    input  logic [7:0]  ld_min,
    input  logic [7:0]  ld_hour,
    input  logic [11:0] ld_day,
    input  logic [7:0]  ld_year,
    output logic [31:0] ex_sig_B_code,
    output logic        frame_start,
    output logic [6:0]  sym_idx,
    output logic        load_err
);

    localparam int            CW       = $clog2(NUM_10MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_10MS);
    localparam logic [6:0]    IDX_LAST = 7'(SYM_NUM - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    bcd_time_t     time_r;
    bcd_time_t     ld_t;
    bcd_time_t     snap_t;
    bcd_time_t     nxt_t;
    logic          ld_ok;
    logic          load_ok;
    logic          boundary;
    logic          start_frame;
    logic [23:0]   snap_hms;
    logic [16:0]   sbs_r;
    logic [99:0]   frame_r;
    logic [99:0]   frame_word;
    logic [6:0]    idx_nx;
    logic [31:0]   code_nx;

    assign ld_t    = {ld_year, ld_day, ld_hour, ld_min, ld_sec};
    assign load_ok = time_load && ld_ok;

    // A valid load on the symbol-0 slot goes straight into that frame.
    assign snap_t = load_ok ? ld_t : time_r;

    bcd_time_inc u_inc (
        .cur    (snap_t),
        .chk    (ld_t),
        .nxt    (nxt_t),
        .chk_ok (ld_ok)
    );

    assign boundary    = (cnt == CNT_LAST);
    assign start_frame = en &&
                         ((state == ST_IDLE) || (sym_idx == IDX_LAST));

    assign frame_word = frame_r | place_sbs(sbs_r);
    assign idx_nx     = sym_idx + 7'd1;
    assign code_nx    = MARK_MASK[idx_nx] ? SYM_P
                      : (frame_word[idx_nx] ? SYM_1 : SYM_0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            sym_idx       <= '0;
            ex_sig_B_code <= '0;
            frame_start   <= 1'b0;
            load_err      <= 1'b0;
            time_r        <= RESET_TIME;
            snap_hms      <= '0;
            sbs_r         <= '0;
            frame_r       <= '0;
        end else begin
            cnt         <= boundary ? '0 : cnt + CW'(1);
            frame_start <= 1'b0;
            load_err    <= time_load && !ld_ok;

            // snap_hms only moves at symbol 0, so SBS settles long
            // before slot 80 and always matches its own frame.
            sbs_r <= calc_sbs(snap_hms[23:16], snap_hms[15:8],
                              snap_hms[7:0]);

            if (boundary && start_frame)
                time_r <= nxt_t;
            else if (load_ok)
                time_r <= ld_t;

            if (boundary) begin
                unique case (1'b1)
                    !en: begin
                        state         <= ST_IDLE;
                        sym_idx       <= '0;
                        ex_sig_B_code <= '0;
                    end
                    start_frame: begin
                        state         <= ST_RUN;
                        sym_idx       <= '0;
                        ex_sig_B_code <= SYM_P;
                        frame_start   <= 1'b1;
                        frame_r       <= build_frame(snap_t);
                        snap_hms      <= {snap_t.hour, snap_t.min,
                                          snap_t.sec};
                    end
                    default: begin
                        sym_idx       <= idx_nx;
                        ex_sig_B_code <= code_nx;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irig_b_frame_gen.sv
// Directed bench for irig_b_frame_gen with a 100-cycle symbol slot.
// Captures frames symbol by symbol and decodes the BCD fields.
module tb_irig_b_frame_gen;

    localparam int N = 99;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        time_load = 1'b0;
    logic [7:0]  ld_sec = '0;
    logic [7:0]  ld_min = '0;
    logic [7:0]  ld_hour = '0;
    logic [11:0] ld_day = 12'h001;
    logic [7:0]  ld_year = '0;
    logic [31:0] code;
    logic        frame_start;
    logic [6:0]  sym_idx;
    logic        load_err;

    int vectors = 0;
    int errs = 0;
    int unsigned codes [100];
    int unsigned idxs [100];

    always #5 clk = ~clk;

    irig_b_frame_gen #(.NUM_10MS(N), .SYM_NUM(100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .time_load     (time_load),
        .ld_sec        (ld_sec),
        .ld_min        (ld_min),
        .ld_hour       (ld_hour),
        .ld_day        (ld_day),
        .ld_year       (ld_year),
        .ex_sig_B_code (code),
        .frame_start   (frame_start),
        .sym_idx       (sym_idx),
        .load_err      (load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_load(input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic [11:0] d,
                              input logic [7:0] y);
        ld_hour = h; ld_min = m; ld_sec = s; ld_day = d; ld_year = y;
        time_load = 1'b1;
        @(negedge clk);
        time_load = 1'b0;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic [11:0] d,
                        input logic [7:0] y);
        pulse_load(h, m, s, d, y);
        chk("load_ok_no_err", 32'(load_err), 32'd0);
    endtask

    task automatic capture(input int n);
        int t;
        t = 0;
        en = 1'b1;
        while (frame_start !== 1'b1 && t < 12000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_start_seen", 32'(frame_start), 32'd1);
        for (int k = 0; k < n; k++) begin
            codes[k] = code;
            idxs[k] = 32'(sym_idx);
            repeat (N + 1) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (code !== 32'd0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", code, 32'd0);
    endtask

    function automatic int fld(input int s, input int n);
        int v;
        v = 0;
        for (int i = 0; i < n; i++)
            if (codes[s + i] == 32'd49) v |= (1 << i);
        return v;
    endfunction

    task automatic check_time(input string tag, input logic [7:0] h,
                              input logic [7:0] m, input logic [7:0] s,
                              input logic [11:0] d, input logic [7:0] y);
        chk({tag, "_sec"}, fld(1, 4) + (fld(6, 3) << 4), 32'(s));
        chk({tag, "_min"}, fld(10, 4) + (fld(15, 3) << 4), 32'(m));
        chk({tag, "_hour"}, fld(20, 4) + (fld(25, 2) << 4), 32'(h));
        chk({tag, "_day"},
            fld(30, 4) + (fld(35, 4) << 4) + (fld(40, 2) << 8), 32'(d));
        chk({tag, "_year"}, fld(50, 4) + (fld(55, 4) << 4), 32'(y));
    endtask

    initial begin
        int bad;
        int mk [11];
        mk = '{0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99};

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk("rst_code", code, 32'd0);
        chk("rst_idx", 32'(sym_idx), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_lerr", 32'(load_err), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (101) @(negedge clk);
            chk("idle_code", code, 32'd0);
            chk("idle_idx", 32'(sym_idx), 32'd0);
            chk("idle_fs", 32'(frame_start), 32'd0);
        end

        // 2: 12:34:56 day 123 year 23
        load(8'h12, 8'h34, 8'h56, 12'h123, 8'h23);
        capture(100);
        bad = 0;
        for (int k = 0; k < 100; k++)
            if (idxs[k] != 32'(k)) bad++;
        chk("idx_sequence_bad", bad, 0);
        for (int i = 0; i < 11; i++)
            chk("marker", codes[mk[i]], 32'd80);
        bad = 0;
        for (int k = 0; k < 100; k++)
            if (codes[k] == 32'd80) bad++;
        chk("marker_total", bad, 11);
        chk("pos1", codes[1], 32'd48);
        chk("pos2", codes[2], 32'd49);
        chk("pos3", codes[3], 32'd49);
        chk("pos4", codes[4], 32'd48);
        chk("pos6", codes[6], 32'd49);
        chk("pos7", codes[7], 32'd48);
        chk("pos8", codes[8], 32'd49);
        chk("pos30", codes[30], 32'd49);
        chk("pos31", codes[31], 32'd49);
        chk("pos32", codes[32], 32'd48);
        chk("pos33", codes[33], 32'd48);
        check_time("f1", 8'h12, 8'h34, 8'h56, 12'h123, 8'h23);
        // 45296 = 0xB0F0: low 9 bits 0x0F0, bits 16:9 = 0x58
        chk("sbs_lo", fld(80, 9), 32'h0F0);
        chk("sbs_hi", fld(90, 8), 32'h58);
        chk("pos98", codes[98], 32'd48);
        capture(59);
        check_time("f2", 8'h12, 8'h34, 8'h57, 12'h123, 8'h23);
        en = 1'b0;
        wait_idle();

        // 3: rollover, non-leap then leap year
        load(8'h23, 8'h59, 8'h59, 12'h365, 8'h23);
        capture(1); en = 1'b0; wait_idle();
        capture(59);
        check_time("roll23", 8'h00, 8'h00, 8'h00, 12'h001, 8'h24);
        en = 1'b0; wait_idle();
        load(8'h23, 8'h59, 8'h59, 12'h365, 8'h24);
        capture(1); en = 1'b0; wait_idle();
        capture(59);
        check_time("leap365", 8'h00, 8'h00, 8'h00, 12'h366, 8'h24);
        en = 1'b0; wait_idle();
        load(8'h23, 8'h59, 8'h59, 12'h366, 8'h24);
        capture(1); en = 1'b0; wait_idle();
        capture(59);
        check_time("leap366", 8'h00, 8'h00, 8'h00, 12'h001, 8'h25);
        en = 1'b0; wait_idle();

        // 4: load on the symbol-0 slot
        en = 1'b1;
        ld_hour = 8'h10; ld_min = 8'h20; ld_sec = 8'h30;
        ld_day = 12'h045; ld_year = 8'h07;
        repeat (N) @(negedge clk);
        time_load = 1'b1;
        @(negedge clk);
        time_load = 1'b0;
        chk("s0load_fs", 32'(frame_start), 32'd1);
        chk("s0load_err", 32'(load_err), 32'd0);
        capture(59);
        check_time("s0load", 8'h10, 8'h20, 8'h30, 12'h045, 8'h07);
        capture(59);
        check_time("s0next", 8'h10, 8'h20, 8'h31, 12'h045, 8'h07);
        en = 1'b0; wait_idle();

        // 5: abort at symbol 42, then restart
        capture(42);
        chk("abort_at", 32'(sym_idx), 32'd42);
        en = 1'b0;
        repeat (N + 1) @(negedge clk);
        chk("abort_code", code, 32'd0);
        chk("abort_idx", 32'(sym_idx), 32'd0);
        chk("abort_fs", 32'(frame_start), 32'd0);
        capture(59);
        chk("restart_idx0", idxs[0], 32'd0);
        chk("restart_p", codes[0], 32'd80);
        check_time("restart", 8'h10, 8'h20, 8'h33, 12'h045, 8'h07);
        en = 1'b0; wait_idle();

        // 6: rejected loads
        pulse_load(8'h01, 8'h02, 8'h5A, 12'h100, 8'h30);
        chk("bad_sec_err", 32'(load_err), 32'd1);
        @(negedge clk);
        chk("bad_sec_err_end", 32'(load_err), 32'd0);
        pulse_load(8'h01, 8'h02, 8'h03, 12'h367, 8'h23);
        chk("bad_day_err", 32'(load_err), 32'd1);
        @(negedge clk);
        chk("bad_day_err_end", 32'(load_err), 32'd0);
        capture(59);
        check_time("after_bad", 8'h10, 8'h20, 8'h34, 12'h045, 8'h07);
        en = 1'b0; wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
